alu_writeback: RTL and testbench

- Consumer end of the Shift/ALU datapath: takes the ALU result F and the ALU flags NZCV for each issued operation.
- Evaluates the ARM condition field against the architectural flag register and conditionally updates those flags (S bit).
- Queues the register-file write in a 2-entry buffer and drains it over a ready/ack handshake to the register file.
- Sits between ALU and register file/CPSR and supplies the current flags back to the shifter/ALU (CF, VF inputs).

---
 rtl/alu_wb_pkg.sv | 59 +++++
 rtl/wb_fifo.sv | 88 ++++++++
 rtl/alu_writeback.sv | 121 ++++++++++++
 tb/tb_alu_writeback.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback stage: condition codes, flag bit
// positions and the ARM condition evaluator.
package alu_wb_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n;
    logic z;
    logic c;
    logic v;
    logic result;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: result = z;
      COND_NE: result = !z;
      COND_CS: result = c;
      COND_CC: result = !c;
      COND_MI: result = n;
      COND_PL: result = !n;
      COND_VS: result = v;
      COND_VC: result = !v;
      COND_HI: result = c && !z;
      COND_LS: result = !c || z;
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = !z && (n == v);
      COND_LE: result = z || (n != v);
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b0;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO whose head entry is held in a register, so the
// consumer sees glitch-free, stable outputs.
module wb_fifo
  import alu_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic [W-1:0]  head_r;

  logic          push_ok_s;
  logic          pop_ok_s;
  logic [PW-1:0] rd_ptr_next_s;
  logic [PW:0]   count_next_s;
  logic [W-1:0]  head_next_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(PW+1){1'b0}});
  assign count     = count_r;
  assign head      = head_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Next read pointer, occupancy and head value after this edge's push/pop.
  always_comb begin
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    head_next_s   = head_r;
    if (pop_ok_s) begin
      rd_ptr_next_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + (PW+1)'(1);
      2'b01:   count_next_s = count_r - (PW+1)'(1);
      default: count_next_s = count_r;
    endcase
    // A push landing where the new read pointer points becomes the head at once.
    if (count_next_s == {(PW+1){1'b0}}) begin
      head_next_s = head_r;
    end else if (push_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = push_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Storage, pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      head_r   <= {W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: condition check, flag update and buffered register-file write.
// Optional macro ALU_WB_PCLOAD_EN adds a pc_load/pc_value pulse on r15 writes.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    cond,
  input  logic          s_bit,
  input  logic [AW-1:0] rd_addr,
  input  logic          wr_en,
  input  logic [DW-1:0] F,
  input  logic [3:0]    nzcv_alu,
  output logic [3:0]    nzcv,
  output logic          cond_pass,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_data,
  input  logic          rf_ack,
  output logic [CW-1:0] retired_cnt,
  output logic [CW-1:0] skipped_cnt
`ifdef ALU_WB_PCLOAD_EN
  ,
  output logic          pc_load,
  output logic [DW-1:0] pc_value
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [3:0]       nzcv_r;
  logic [CW-1:0]    retired_cnt_r;
  logic [CW-1:0]    skipped_cnt_r;
  logic             accept_s;
  logic             pass_s;
  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [PW:0]      fifo_count_s;
  logic [AW+DW-1:0] head_s;

  // Ready comes only from registered occupancy: no path from rf_ack to the ALU.
  assign in_ready  = (fifo_count_s < FULL_CNT);
  assign accept_s  = in_valid && in_ready;
  assign pass_s    = cond_eval(cond, nzcv_r);
  assign cond_pass = pass_s;
  assign push_s    = accept_s && pass_s && wr_en && !fifo_full_s;
  assign pop_s     = rf_ack && !fifo_empty_s;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({rd_addr, F}),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign rf_we              = !fifo_empty_s;
  assign {rf_addr, rf_data} = head_s;
  assign nzcv               = nzcv_r;
  assign retired_cnt        = retired_cnt_r;
  assign skipped_cnt        = skipped_cnt_r;

  // Architectural flags and retire/skip statistics, updated per transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_r        <= 4'b0000;
      retired_cnt_r <= {CW{1'b0}};
      skipped_cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      if (pass_s) begin
        if (s_bit) begin
          nzcv_r <= nzcv_alu;
        end
        retired_cnt_r <= retired_cnt_r + CW'(1);
      end else begin
        skipped_cnt_r <= skipped_cnt_r + CW'(1);
      end
    end
  end

`ifdef ALU_WB_PCLOAD_EN
  localparam logic [AW-1:0] PC_ADDR = AW'(15);

  logic          pc_load_r;
  logic [DW-1:0] pc_value_r;

  assign pc_load  = pc_load_r;
  assign pc_value = pc_value_r;

  // One-cycle pulse after an acknowledged r15 write, carrying its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_load_r  <= 1'b0;
      pc_value_r <= {DW{1'b0}};
    end else begin
      pc_load_r <= pop_s && (rf_addr == PC_ADDR);
      if (pop_s && (rf_addr == PC_ADDR)) begin
        pc_value_r <= rf_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback; define ALU_WB_PCLOAD_EN to cover pc_load.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  cond = 4'b0000;
  logic        s_bit = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic        wr_en = 1'b0;
  logic [31:0] F = 32'd0;
  logic [3:0]  nzcv_alu = 4'b0000;
  logic [3:0]  nzcv;
  logic        cond_pass;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_ack = 1'b0;
  logic [15:0] retired_cnt;
  logic [15:0] skipped_cnt;
`ifdef ALU_WB_PCLOAD_EN
  logic        pc_load;
  logic [31:0] pc_value;
`endif

  int total = 0;
  int bad = 0;

  logic [3:0]  m_nzcv = 4'b0000;
  logic [15:0] m_ret = 16'd0;
  logic [15:0] m_skip = 16'd0;
  logic [35:0] sb[$];

  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] NE = 4'b0001;

  alu_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cond        (cond),
    .s_bit       (s_bit),
    .rd_addr     (rd_addr),
    .wr_en       (wr_en),
    .F           (F),
    .nzcv_alu    (nzcv_alu),
    .nzcv        (nzcv),
    .cond_pass   (cond_pass),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .rf_ack      (rf_ack),
    .retired_cnt (retired_cnt),
    .skipped_cnt (skipped_cnt)
`ifdef ALU_WB_PCLOAD_EN
    ,
    .pc_load     (pc_load),
    .pc_value    (pc_value)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // ARM decode: pairs of codes share a base test, odd codes invert it.
  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] c, input logic s, input logic w,
                        input logic [3:0] rd, input logic [31:0] f, input logic [3:0] fl);
    in_valid = 1'b1; cond = c; s_bit = s; wr_en = w; rd_addr = rd; F = f; nzcv_alu = fl;
  endtask

  task automatic issue(input logic [3:0] c, input logic s, input logic w,
                       input logic [3:0] rd, input logic [31:0] f, input logic [3:0] fl);
    int n;
    bit p;
    set_op(c, s, w, rd, f, fl);
    #1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    p = model_pass(c, m_nzcv);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready got=%b want=1", in_ready);
    end else begin
      total++;
      if (cond_pass !== p) begin
        bad++;
        $display("FAIL cond_pass cond=%b flags=%b got=%b want=%b", c, m_nzcv, cond_pass, p);
      end
      if (p) begin
        if (s) m_nzcv = fl;
        if (w) sb.push_back({rd, f});
        m_ret = m_ret + 16'd1;
      end else begin
        m_skip = m_skip + 16'd1;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_one();
    logic [35:0] exp;
    total++;
    if (rf_we !== 1'b1 || sb.size() == 0) begin
      bad++;
      $display("FAIL drain_we got=%b want=1 queued=%0d", rf_we, sb.size());
      tick();
    end else begin
      exp = sb.pop_front();
      if ({rf_addr, rf_data} !== exp) begin
        bad++;
        $display("FAIL rf_head got=%h/%h want=%h/%h", rf_addr, rf_data, exp[35:32], exp[31:0]);
      end
      rf_ack = 1'b1;
      tick();
      rf_ack = 1'b0;
    end
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      drain_one();
      n++;
    end
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty rf_we got=%b want=0", rf_we);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({nzcv, rf_we, rf_addr, rf_data, in_ready} !== {4'b0000, 1'b0, 4'd0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state nzcv=%b we=%b addr=%h data=%h rdy=%b want 0000/0/0/0/1",
               nzcv, rf_we, rf_addr, rf_data, in_ready);
    end
    total++;
    if (retired_cnt !== 16'd0 || skipped_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", retired_cnt, skipped_cnt);
    end
  endtask

  task automatic test_basic();
    issue(AL, 1'b1, 1'b1, 4'd3, 32'h9a4d882b, 4'b1010);
    total++;
    if (nzcv !== 4'b1010) begin bad++; $display("FAIL basic_nzcv got=%b want=1010", nzcv); end
    total++;
    if ({rf_we, rf_addr, rf_data} !== {1'b1, 4'd3, 32'h9a4d882b}) begin
      bad++;
      $display("FAIL basic_write got=%b/%h/%h want=1/3/9a4d882b", rf_we, rf_addr, rf_data);
    end
    total++;
    if (retired_cnt !== 16'd1) begin bad++; $display("FAIL basic_retired got=%0d want=1", retired_cnt); end
    drain_all();
  endtask

  task automatic test_cond_fail();
    issue(AL, 1'b1, 1'b0, 4'd0, 32'd0, 4'b0100);
    issue(NE, 1'b1, 1'b1, 4'd1, 32'h12345678, 4'b0011);
    total++;
    if (rf_we !== 1'b0 || nzcv !== 4'b0100) begin
      bad++;
      $display("FAIL fail_effect we=%b nzcv=%b want=0/0100", rf_we, nzcv);
    end
    total++;
    if (skipped_cnt !== 16'd1 || skipped_cnt !== m_skip) begin
      bad++;
      $display("FAIL fail_skipped got=%0d want=%0d", skipped_cnt, m_skip);
    end
  endtask

  task automatic test_back_to_back();
    issue(AL, 1'b1, 1'b0, 4'd0, 32'd0, 4'b0000);
    issue(AL, 1'b1, 1'b0, 4'd0, 32'd0, 4'b0100);
    issue(EQ, 1'b0, 1'b1, 4'd5, 32'hf0000000, 4'b0000);
    total++;
    if ({rf_we, rf_addr, rf_data} !== {1'b1, 4'd5, 32'hf0000000}) begin
      bad++;
      $display("FAIL b2b_write got=%b/%h/%h want=1/5/f0000000", rf_we, rf_addr, rf_data);
    end
    drain_all();
    rf_ack = 1'b1;
    tick();
    rf_ack = 1'b0;
    total++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stray_ack we=%b rdy=%b want=0/1", rf_we, in_ready);
    end
  endtask

  task automatic test_cond_table();
    logic [3:0] pats [5];
    logic [3:0] cc;
    pats[0] = 4'b0000; pats[1] = 4'b0100; pats[2] = 4'b1001; pats[3] = 4'b0011; pats[4] = 4'b1110;
    for (int p = 0; p < 5; p++) begin
      issue(AL, 1'b1, 1'b0, 4'd0, 32'd0, pats[p]);
      total++;
      if (nzcv !== pats[p]) begin bad++; $display("FAIL table_nzcv got=%b want=%b", nzcv, pats[p]); end
      for (int c = 0; c < 16; c++) begin
        cc = 4'(c);
        cond = cc;
        #1;
        total++;
        if (cond_pass !== model_pass(cc, pats[p])) begin
          bad++;
          $display("FAIL table cond=%b flags=%b got=%b want=%b", cc, pats[p], cond_pass,
                   model_pass(cc, pats[p]));
        end
      end
      issue(4'b1111, 1'b1, 1'b1, 4'd2, 32'h0bad0bad, 4'b0001);
    end
    total++;
    if (retired_cnt !== m_ret || skipped_cnt !== m_skip || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL table_counts got=%0d/%0d/%b want=%0d/%0d/0", retired_cnt, skipped_cnt, rf_we,
               m_ret, m_skip);
    end
  endtask

  task automatic test_backpressure();
    issue(AL, 1'b0, 1'b1, 4'd1, 32'ha1a1a1a1, 4'b0000);
    issue(AL, 1'b0, 1'b1, 4'd2, 32'ha2a2a2a2, 4'b0000);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full in_ready got=%b want=0", in_ready); end
    set_op(AL, 1'b0, 1'b1, 4'd3, 32'ha3a3a3a3, 4'b0000);
    tick();
    tick();
    total++;
    if (retired_cnt !== m_ret || rf_addr !== 4'd1 || rf_data !== 32'ha1a1a1a1) begin
      bad++;
      $display("FAIL bp_hold ret=%0d addr=%h data=%h want=%0d/1/a1a1a1a1", retired_cnt, rf_addr,
               rf_data, m_ret);
    end
    drain_one();
    total++;
    if (in_ready !== 1'b1 || retired_cnt !== m_ret) begin
      bad++;
      $display("FAIL bp_release rdy=%b ret=%0d want=1/%0d", in_ready, retired_cnt, m_ret);
    end
    issue(AL, 1'b0, 1'b1, 4'd3, 32'ha3a3a3a3, 4'b0000);
    drain_all();
  endtask

  task automatic test_push_pop_same();
    logic [35:0] exp;
    issue(AL, 1'b0, 1'b1, 4'd7, 32'h77777777, 4'b0000);
    set_op(AL, 1'b0, 1'b1, 4'd9, 32'h99999999, 4'b0000);
    rf_ack = 1'b1;
    exp = sb.pop_front();
    total++;
    if ({rf_addr, rf_data} !== exp) begin
      bad++;
      $display("FAIL pp_head got=%h/%h want=%h/%h", rf_addr, rf_data, exp[35:32], exp[31:0]);
    end
    sb.push_back({4'd9, 32'h99999999});
    m_ret = m_ret + 16'd1;
    tick();
    rf_ack = 1'b0;
    in_valid = 1'b0;
    total++;
    if ({rf_we, rf_addr, rf_data, in_ready} !== {1'b1, 4'd9, 32'h99999999, 1'b1}) begin
      bad++;
      $display("FAIL pp_switch got=%b/%h/%h rdy=%b want=1/9/99999999/1", rf_we, rf_addr, rf_data,
               in_ready);
    end
    issue(AL, 1'b0, 1'b1, 4'd10, 32'haaaa0000, 4'b0000);
    set_op(AL, 1'b0, 1'b1, 4'd11, 32'hbbbb0000, 4'b0000);
    drain_one();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || retired_cnt !== m_ret || rf_addr !== 4'd10) begin
      bad++;
      $display("FAIL pp_full rdy=%b ret=%0d addr=%h want=1/%0d/a", in_ready, retired_cnt, rf_addr,
               m_ret);
    end
    drain_all();
  endtask

  task automatic test_reset_mid();
    issue(AL, 1'b1, 1'b1, 4'd1, 32'h11111111, 4'b1111);
    issue(AL, 1'b0, 1'b1, 4'd2, 32'h22222222, 4'b0000);
    total++;
    if (in_ready !== 1'b0 || nzcv !== 4'b1111) begin
      bad++;
      $display("FAIL rm_setup rdy=%b nzcv=%b want=0/1111", in_ready, nzcv);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({rf_we, nzcv, in_ready} !== {1'b0, 4'b0000, 1'b1} ||
        retired_cnt !== 16'd0 || skipped_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rm_clear we=%b nzcv=%b rdy=%b ret=%0d skip=%0d want=0/0000/1/0/0", rf_we,
               nzcv, in_ready, retired_cnt, skipped_cnt);
    end
    tick();
    rst = 1'b0;
    sb.delete();
    m_nzcv = 4'b0000;
    m_ret = 16'd0;
    m_skip = 16'd0;
    tick();
    total++;
    if (rf_we !== 1'b0 || retired_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rm_after we=%b ret=%0d want=0/0", rf_we, retired_cnt);
    end
  endtask

  task automatic test_pc_load();
`ifdef ALU_WB_PCLOAD_EN
    issue(AL, 1'b0, 1'b1, 4'd15, 32'h00000100, 4'b0000);
    total++;
    if (pc_load !== 1'b0) begin bad++; $display("FAIL pc_early got=%b want=0", pc_load); end
    drain_one();
    total++;
    if (pc_load !== 1'b1 || pc_value !== 32'h00000100) begin
      bad++;
      $display("FAIL pc_pulse got=%b/%h want=1/00000100", pc_load, pc_value);
    end
    tick();
    total++;
    if (pc_load !== 1'b0) begin bad++; $display("FAIL pc_width got=%b want=0", pc_load); end
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_cond_fail();
    test_back_to_back();
    test_cond_table();
    test_backpressure();
    test_push_pop_same();
    test_reset_mid();
    test_pc_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
